// File: rtl/alu_bitserial_sequencer_pkg.sv
// Shared constants and types for the bit-serial ALU sequencer.
package alu_bitserial_sequencer_pkg;

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned SOP_W  = 2;

  // ALU control codes
  localparam logic [CTRL_W-1:0] CTRL_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] CTRL_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] CTRL_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] CTRL_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] CTRL_SLT = 4'b0111;
  localparam logic [CTRL_W-1:0] CTRL_NOR = 4'b1100;

  // 1-bit slice Operation select
  localparam logic [SOP_W-1:0] SOP_AND  = 2'b00;
  localparam logic [SOP_W-1:0] SOP_OR   = 2'b01;
  localparam logic [SOP_W-1:0] SOP_ADD  = 2'b10;
  localparam logic [SOP_W-1:0] SOP_LESS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Decoded slice controls for one operation
  typedef struct packed {
    logic             ainvert;
    logic             binvert;
    logic             cin0;
    logic [SOP_W-1:0] operation;
    logic             is_arith;
    logic             is_slt;
    logic             legal;
  } dec_t;

endpackage

// File: rtl/alu_serial_decode.sv
// Combinational decode of the 4-bit ALU control code into slice controls.
module alu_serial_decode
  import alu_bitserial_sequencer_pkg::*;
(
  input  logic [CTRL_W-1:0] i_alu_ctrl,
  output dec_t              o_dec_c
);

  // Map control code to invert/carry/operation and op-class flags
  always_comb begin
    o_dec_c = '0;
    case (i_alu_ctrl)
      CTRL_AND: begin
        o_dec_c.operation = SOP_AND;
        o_dec_c.legal     = 1'b1;
      end
      CTRL_OR: begin
        o_dec_c.operation = SOP_OR;
        o_dec_c.legal     = 1'b1;
      end
      CTRL_ADD: begin
        o_dec_c.operation = SOP_ADD;
        o_dec_c.is_arith  = 1'b1;
        o_dec_c.legal     = 1'b1;
      end
      CTRL_SUB: begin
        o_dec_c.binvert   = 1'b1;
        o_dec_c.cin0      = 1'b1;
        o_dec_c.operation = SOP_ADD;
        o_dec_c.is_arith  = 1'b1;
        o_dec_c.legal     = 1'b1;
      end
      CTRL_SLT: begin
        o_dec_c.binvert   = 1'b1;
        o_dec_c.cin0      = 1'b1;
        o_dec_c.operation = SOP_ADD;
        o_dec_c.is_arith  = 1'b1;
        o_dec_c.is_slt    = 1'b1;
        o_dec_c.legal     = 1'b1;
      end
      CTRL_NOR: begin
        o_dec_c.ainvert   = 1'b1;
        o_dec_c.binvert   = 1'b1;
        o_dec_c.operation = SOP_AND;
        o_dec_c.legal     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_bitserial_sequencer.sv
// Bit-serial sequencer driving one external 1-bit ALU slice, LSB first.
module alu_bitserial_sequencer
  import alu_bitserial_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDXW  = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CTRL_W-1:0]    alu_ctrl,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 zero,
  output logic                 overflow,
  output logic                 illegal,
  output logic                 slice_a,
  output logic                 slice_b,
  output logic                 slice_less,
  output logic                 slice_ainvert,
  output logic                 slice_binvert,
  output logic                 slice_cin,
  output logic [SOP_W-1:0]     slice_operation,
  input  logic                 slice_result,
  input  logic                 slice_carryout
);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;         // operand bits not yet presented, LSB next
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic             r_is_arith;
  logic             r_is_slt;
  logic             r_msb;       // MSB sum bit, kept for the SLT fix-up

  dec_t             w_dec;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;
  logic             w_ovf;

  alu_serial_decode u_decode (
    .i_alu_ctrl (alu_ctrl),
    .o_dec_c    (w_dec)
  );

  // SLT fix-up is done here, so the slice Less input is never used
  assign slice_less = 1'b0;

  // Next result shifts the current slice bit in from the top
  always_comb begin
    w_res_next = {slice_result, result[WIDTH-1:1]};
    w_last     = (r_idx == IDXW'(WIDTH-1));
    w_ovf      = r_is_arith & (slice_cin ^ slice_carryout);
  end

  // Sequencer FSM; slice_cin doubles as the carry register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_a             <= '0;
      r_b             <= '0;
      r_idx           <= '0;
      r_is_arith      <= 1'b0;
      r_is_slt        <= 1'b0;
      r_msb           <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      result          <= '0;
      zero            <= 1'b0;
      overflow        <= 1'b0;
      illegal         <= 1'b0;
      slice_a         <= 1'b0;
      slice_b         <= 1'b0;
      slice_ainvert   <= 1'b0;
      slice_binvert   <= 1'b0;
      slice_cin       <= 1'b0;
      slice_operation <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy       <= 1'b1;
            result     <= '0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
            r_idx      <= '0;
            r_msb      <= 1'b0;
            r_is_arith <= w_dec.is_arith;
            r_is_slt   <= w_dec.is_slt;
            if (w_dec.legal) begin
              illegal         <= 1'b0;
              slice_a         <= operand_a[0];
              slice_b         <= operand_b[0];
              r_a             <= operand_a >> 1;
              r_b             <= operand_b >> 1;
              slice_ainvert   <= w_dec.ainvert;
              slice_binvert   <= w_dec.binvert;
              slice_cin       <= w_dec.cin0;
              slice_operation <= w_dec.operation;
              r_state         <= ST_RUN;
            end else begin
              illegal <= 1'b1;
              zero    <= 1'b1;
              done    <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          result    <= w_res_next;
          slice_cin <= slice_carryout;
          if (w_last) begin
            overflow        <= w_ovf;
            r_msb           <= slice_result;
            slice_a         <= 1'b0;
            slice_b         <= 1'b0;
            slice_ainvert   <= 1'b0;
            slice_binvert   <= 1'b0;
            slice_cin       <= 1'b0;
            slice_operation <= '0;
            if (r_is_slt) begin
              r_state <= ST_FIX;
            end else begin
              zero    <= (w_res_next == '0);
              done    <= 1'b1;
              r_state <= ST_DONE;
            end
          end else begin
            r_idx   <= r_idx + 1'b1;
            slice_a <= r_a[0];
            slice_b <= r_b[0];
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
          end
        end
        ST_FIX: begin
          result  <= {{(WIDTH-1){1'b0}}, r_msb ^ overflow};
          zero    <= ~(r_msb ^ overflow);
          done    <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
